// File: rtl/reg_scoreboard.sv
// Register scoreboard for the ID stage. It tracks every in-flight register write with a
// latency countdown and a generation tag, and drives stall plus per-source forward-ready flags.
module reg_scoreboard #(
    parameter int AW     = 5,
    parameter int LW     = 3,
    parameter int MAXLAT = 4,
    parameter int TW     = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          issue_valid_i,
    input  logic          issue_we_i,
    input  logic [AW-1:0] issue_rd_i,
    input  logic [LW-1:0] issue_lat_i,
    input  logic          use_a_i,
    input  logic [AW-1:0] src_a_i,
    input  logic          use_b_i,
    input  logic [AW-1:0] src_b_i,
    input  logic          flush_i,
    input  logic          wb_valid_i,
    input  logic [AW-1:0] wb_rd_i,
    input  logic [TW-1:0] wb_tag_i,
    output logic          stall_o,
    output logic [TW-1:0] issue_tag_o,
    output logic          fwd_a_o,
    output logic          fwd_b_o,
    output logic [AW:0]   busy_cnt_o
);

    localparam int            NREG     = 2 ** AW;
    localparam logic [LW-1:0] MAXLAT_L = LW'(MAXLAT);

    typedef logic [AW:0] busy_t;

    typedef struct packed {
        logic          pending;
        logic [LW-1:0] cnt;
        logic [TW-1:0] gen;
    } entry_t;

    entry_t        tab_q [NREG];
    entry_t        tab_d [NREG];
    busy_t         busy_cnt_q;
    busy_t         busy_cnt_d;

    logic          nr_a;
    logic          nr_b;
    logic          nr_rd;
    logic          accept;
    logic          retire;
    logic          busy_inc;
    logic          busy_dec;
    logic [LW-1:0] lat_eff;

    // Register 0 is hardwired: it never stalls or forwards, whatever the table holds.
    assign nr_a  = (src_a_i != '0) && tab_q[src_a_i].pending && (tab_q[src_a_i].cnt != '0);
    assign nr_b  = (src_b_i != '0) && tab_q[src_b_i].pending && (tab_q[src_b_i].cnt != '0);
    assign nr_rd = (issue_rd_i != '0) && tab_q[issue_rd_i].pending
                   && (tab_q[issue_rd_i].cnt != '0);

    assign stall_o = issue_valid_i && !flush_i
                     && ((use_a_i && nr_a) || (use_b_i && nr_b) || (issue_we_i && nr_rd));

    assign fwd_a_o = use_a_i && (src_a_i != '0) && tab_q[src_a_i].pending
                     && (tab_q[src_a_i].cnt == '0);
    assign fwd_b_o = use_b_i && (src_b_i != '0) && tab_q[src_b_i].pending
                     && (tab_q[src_b_i].cnt == '0);

    assign accept = issue_valid_i && issue_we_i && !stall_o && !flush_i && (issue_rd_i != '0);

    // A retire only counts when it carries the newest tag; older writes to the same
    // register are bubbles that must not clear a newer pending producer.
    assign retire = wb_valid_i && (wb_rd_i != '0) && tab_q[wb_rd_i].pending
                    && (wb_tag_i == tab_q[wb_rd_i].gen);

    assign issue_tag_o = tab_q[issue_rd_i].gen + TW'(1);
    assign lat_eff     = (issue_lat_i > MAXLAT_L) ? MAXLAT_L : issue_lat_i;

    assign busy_inc = accept && !tab_q[issue_rd_i].pending;
    assign busy_dec = retire && !(accept && (issue_rd_i == wb_rd_i));

    always_comb begin
        // NOTE: every variable driven here gets a full default first, so no path can
        // leave it unassigned and infer a latch.
        tab_d      = tab_q;
        busy_cnt_d = busy_cnt_q;

        for (int r = 1; r < NREG; r++) begin
            if (tab_q[AW'(r)].pending && (tab_q[AW'(r)].cnt != '0)) begin
                tab_d[AW'(r)].cnt = tab_q[AW'(r)].cnt - LW'(1);
            end
        end

        if (retire) begin
            tab_d[wb_rd_i].pending = 1'b0;
            tab_d[wb_rd_i].cnt     = '0;
        end

        // Issue is applied last so it overrides both the countdown and a same-cycle retire.
        if (accept) begin
            tab_d[issue_rd_i].pending = 1'b1;
            tab_d[issue_rd_i].cnt     = lat_eff;
            tab_d[issue_rd_i].gen     = issue_tag_o;
        end

        if (busy_inc && !busy_dec) begin
            busy_cnt_d = busy_cnt_q + busy_t'(1);
        end else if (busy_dec && !busy_inc) begin
            busy_cnt_d = busy_cnt_q - busy_t'(1);
        end
    end

    // NOTE: the table is a bank of flops, not a RAM, so it is safe and required to clear
    // it on reset; the generation counters must restart so the first tag is 1 again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tab_q      <= '{default: '0};
            busy_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            tab_q      <= tab_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt_o = busy_cnt_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios then randomized traffic,
// checked against a time-stamp based reference model of the scoreboard rules.
module tb_reg_scoreboard;

    localparam int AW     = 5;
    localparam int LW     = 3;
    localparam int MAXLAT = 4;
    localparam int TW     = 2;
    localparam int NREG   = 2 ** AW;

    logic          clk;
    logic          rst;
    logic          issue_valid_i;
    logic          issue_we_i;
    logic [AW-1:0] issue_rd_i;
    logic [LW-1:0] issue_lat_i;
    logic          use_a_i;
    logic [AW-1:0] src_a_i;
    logic          use_b_i;
    logic [AW-1:0] src_b_i;
    logic          flush_i;
    logic          wb_valid_i;
    logic [AW-1:0] wb_rd_i;
    logic [TW-1:0] wb_tag_i;
    logic          stall_o;
    logic [TW-1:0] issue_tag_o;
    logic          fwd_a_o;
    logic          fwd_b_o;
    logic [AW:0]   busy_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: a write is outstanding until retired and becomes forwardable at an absolute
    // edge count, instead of tracking a per-register countdown.
    bit m_pend  [NREG];
    int m_ready [NREG];
    int m_gen   [NREG];
    int m_now;

    reg_scoreboard #(.AW(AW), .LW(LW), .MAXLAT(MAXLAT), .TW(TW)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid_i(issue_valid_i),
        .issue_we_i   (issue_we_i),
        .issue_rd_i   (issue_rd_i),
        .issue_lat_i  (issue_lat_i),
        .use_a_i      (use_a_i),
        .src_a_i      (src_a_i),
        .use_b_i      (use_b_i),
        .src_b_i      (src_b_i),
        .flush_i      (flush_i),
        .wb_valid_i   (wb_valid_i),
        .wb_rd_i      (wb_rd_i),
        .wb_tag_i     (wb_tag_i),
        .stall_o      (stall_o),
        .issue_tag_o  (issue_tag_o),
        .fwd_a_o      (fwd_a_o),
        .fwd_b_o      (fwd_b_o),
        .busy_cnt_o   (busy_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < NREG; r++) begin
            m_pend[r]  = 1'b0;
            m_ready[r] = 0;
            m_gen[r]   = 0;
        end
    endtask

    function automatic bit m_notready(input int r);
        return (r != 0) && m_pend[r] && (m_now < m_ready[r]);
    endfunction

    function automatic bit m_fwd(input bit use_src, input int r);
        return use_src && (r != 0) && m_pend[r] && (m_now >= m_ready[r]);
    endfunction

    function automatic int m_busy();
        int n = 0;
        for (int r = 0; r < NREG; r++) n += int'(m_pend[r]);
        return n;
    endfunction

    // One clock: drive inputs, check combinational/registered outputs, cross the edge,
    // then advance the model.
    task automatic cyc(input bit iv, input bit we, input int rd, input int lat,
                       input bit ua, input int sa, input bit ub, input int sb,
                       input bit fl, input bit wbv, input int wbrd, input int wbtag);
        bit e_stall;
        bit acc;
        bit ret;
        issue_valid_i = iv;
        issue_we_i    = we;
        issue_rd_i    = AW'(rd);
        issue_lat_i   = LW'(lat);
        use_a_i       = ua;
        src_a_i       = AW'(sa);
        use_b_i       = ub;
        src_b_i       = AW'(sb);
        flush_i       = fl;
        wb_valid_i    = wbv;
        wb_rd_i       = AW'(wbrd);
        wb_tag_i      = TW'(wbtag);
        #1;
        e_stall = iv && !fl
                  && ((ua && m_notready(sa)) || (ub && m_notready(sb)) || (we && m_notready(rd)));
        acc = iv && we && !e_stall && !fl && (rd != 0);
        check("stall", stall_o, e_stall);
        check("fwd_a", fwd_a_o, m_fwd(ua, sa));
        check("fwd_b", fwd_b_o, m_fwd(ub, sb));
        check("busy_cnt", busy_cnt_o, m_busy());
        if (acc) check("issue_tag", issue_tag_o, (m_gen[rd] + 1) % (1 << TW));
        @(posedge clk);
        ret = wbv && (wbrd != 0) && m_pend[wbrd] && (wbtag == m_gen[wbrd]);
        if (ret) m_pend[wbrd] = 1'b0;
        if (acc) begin
            m_pend[rd]  = 1'b1;
            m_ready[rd] = m_now + 1 + ((lat > MAXLAT) ? MAXLAT : lat);
            m_gen[rd]   = (m_gen[rd] + 1) % (1 << TW);
        end
        m_now++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 1'b1;
        issue_valid_i = 1'b0; issue_we_i = 1'b0; issue_rd_i = '0; issue_lat_i = '0;
        use_a_i = 1'b0; src_a_i = '0; use_b_i = 1'b0; src_b_i = '0; flush_i = 1'b0;
        wb_valid_i = 1'b0; wb_rd_i = '0; wb_tag_i = '0;
        model_reset();
        m_now = 0;
        #2;
        check("rst_stall", stall_o, 0);
        check("rst_fwd_a", fwd_a_o, 0);
        check("rst_busy", busy_cnt_o, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // r5 latency 2: dependent reader stalls two cycles, then forwards.
        cyc(1, 1, 5, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 5, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 5, 1);

        // r3 latency 0: forward next cycle while it retires in that same cycle.
        cyc(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 1, 3, 0, 1, 3, 1);
        idle(1);

        // r7 issued twice; the stale retire with the old tag must not clear it.
        cyc(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 7, 1);
        cyc(0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 7, 2);
        idle(1);

        // Writes to r0 are never tracked.
        cyc(1, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0);

        // Flushed issue leaves r9 idle; latency 7 clamps to 4 stall cycles.
        cyc(1, 1, 9, 2, 0, 0, 0, 0, 1, 0, 0, 0);
        cyc(1, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 9, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 1, 9, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 1);

        // Asynchronous reset in the middle of a cycle with r4 still counting down.
        cyc(1, 1, 4, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        issue_valid_i = 1'b1; issue_we_i = 1'b0; use_a_i = 1'b1; src_a_i = AW'(4);
        #1;
        check("pre_rst_stall", stall_o, 1);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_stall", stall_o, 0);
        check("async_rst_busy", busy_cnt_o, 0);
        model_reset();
        #1;
        rst = 1'b0;
        cyc(1, 0, 0, 0, 1, 4, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(2);

        // Randomized traffic over a small register window so hazards are frequent.
        for (int i = 0; i < 1500; i++) begin
            int rd;
            int wbrd;
            int wbtag;
            rd    = int'($urandom_range(0, 7));
            wbrd  = int'($urandom_range(0, 7));
            wbtag = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : m_gen[wbrd];
            cyc(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 2) != 0), rd,
                int'($urandom_range(0, 7)),
                bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                bit'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                bit'($urandom_range(0, 9) == 0),
                bit'($urandom_range(0, 1)), wbrd, wbtag);
        end
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
